mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, combinational-read DPI memory between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time using valid/ready handshakes.
- Sequences the memory access, with optional wait states, and returns a registered response to the winning requester.
- Sits between the core front-end/LSU and the memory model; it is the only driver of the memory's wen/addr/wdata/wstrb.

Parameters:
- MEM_LAT, 0, extra wait cycles between address launch and read-data sampling/write commit (0..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_data  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wstrb  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  LSU response valid (read data or write ack)
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_data  out  DATA_W  read data; for writes, the pre-write word
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte strobes
- mem_read_data  in  DATA_W  memory combinational read data

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
  - Reset forces state IDLE, wait counter 0, owner NONE, resp data registers 0, round-robin pointer = IFU.
  - While reset is high, all *_req_ready, *_resp_valid and mem_wen are 0.
- IDLE:
  - Grant is computed combinationally from the request valids. Only the grantee sees req_ready=1, and only in IDLE.
  - Without the optional feature, grant is fixed priority: LSU over IFU.
  - On handshake (valid&&ready) latch addr, wen, wdata, wstrb and owner, load counter=MEM_LAT, go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS:
  - mem_addr, mem_wdata and mem_wstrb are driven from the latched values.
  - While counter>0, decrement; mem_wen=0.
  - When counter==0:
    - sample mem_read_data into the owner's resp_data register;
    - if latched wen, assert mem_wen for exactly this one cycle;
    - go to RESP.
  - wstrb==0 with wen=1 still pulses mem_wen with strobes 0.
- RESP:
  - The owner's resp_valid is 1; resp_data is held stable.
  - On resp_ready, go to IDLE. The new request is not accepted in the same cycle.
- Latency and throughput:
  - Request accepted at cycle T: access occurs in cycles T+1..T+1+MEM_LAT; resp_valid is first high at T+2+MEM_LAT.
  - Minimum interval between accepts is 3+MEM_LAT cycles.
- Outside ACCESS: mem_wen=0; mem_addr/mem_wdata/mem_wstrb hold their last latched values (0 after reset).
- A non-owner's resp_valid is always 0. Each port has at most one outstanding transaction.
- Reset mid-transaction: the transaction is discarded. No mem_wen pulse follows and no response is issued.
- Request inputs changing after acceptance have no effect.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - When both ports are valid in IDLE, grant goes to the port not granted last, tracked by the round-robin pointer.
  - The pointer updates on every accept.
  - Single requester: that requester wins.
- MEM_ARB_RR_EN undefined: fixed priority, LSU over IFU; no pointer register exists.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {NONE, IFU, LSU};
  - default ADDR_W/DATA_W constants;
  - counter width constant (4 bits).
- Sub-module mem_arb_picker:
  - combinational grant logic from the two valids plus the round-robin pointer;
  - contains the MEM_ARB_RR_EN conditional.

Test Plan:
- MEM_LAT=0, IFU read addr 0x100, memory holds 0xDEADBEEF -> ifu_req_ready in accept cycle T; ifu_resp_valid at T+2 with 0xDEADBEEF; lsu_resp_valid stays 0.
- LSU write addr 0x200, wdata 0x12345678, wstrb 0b0011, old word 0xAAAAAAAA -> mem_wen high exactly one cycle with strobes 0b0011; resp_data 0xAAAAAAAA; subsequent read returns 0xAAAA5678.
- Both ports valid every cycle, fixed priority -> LSU wins every grant. With MEM_ARB_RR_EN -> grants alternate LSU/IFU starting with LSU (pointer reset = IFU).
- MEM_LAT=3, LSU read -> resp_valid at T+5. resp_ready held low 4 cycles -> resp_valid and data stable; no new accept until the cycle after resp_ready.
- Reset asserted during the ACCESS cycle of a write -> no mem_wen pulse; all valid/ready outputs 0 next cycle; the next request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter (optional MEM_ARB_RR_EN round-robin build).
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic [1:0] {NONE, IFU, LSU} owner_e;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational IFU/LSU grant; fixed LSU priority, or round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_picker (
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_lsu_i,
`endif
    output logic ifu_gnt_o,
    output logic lsu_gnt_o
);
`ifdef MEM_ARB_RR_EN
    // on contention the port that did not win the last accept goes first
    assign lsu_gnt_o = lsu_valid_i && (!ifu_valid_i || !last_lsu_i);
`else
    assign lsu_gnt_o = lsu_valid_i;
`endif
    assign ifu_gnt_o = ifu_valid_i && !lsu_gnt_o;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory between IFU and LSU, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_read_data
);
    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   ifu_data_q, ifu_data_d;
    logic [DATA_W-1:0]   lsu_data_q, lsu_data_d;
    logic                ifu_gnt, lsu_gnt, take, commit, done;

    assign take   = state_q == IDLE && (ifu_gnt || lsu_gnt);
    assign commit = state_q == ACCESS && cnt_q == '0;
    assign done   = state_q == RESP && (owner_q == LSU ? lsu_resp_ready : ifu_resp_ready);

`ifdef MEM_ARB_RR_EN
    logic rr_q;
    mem_arb_picker u_picker (
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .last_lsu_i  (rr_q),
        .ifu_gnt_o   (ifu_gnt),
        .lsu_gnt_o   (lsu_gnt)
    );
    // remembers whether the LSU won the most recent accept
    always_ff @(posedge clk)
        rr_q <= reset ? 1'b0 : take ? lsu_gnt : rr_q;
`else
    mem_arb_picker u_picker (
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .ifu_gnt_o   (ifu_gnt),
        .lsu_gnt_o   (lsu_gnt)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ifu_data_q <= '0;
            lsu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ifu_data_q <= ifu_data_d;
            lsu_data_q <= lsu_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ifu_data_d = ifu_data_q;
        lsu_data_d = lsu_data_q;
        if (take) begin
            state_d = ACCESS;
            if (lsu_gnt) owner_d = LSU;
            else owner_d = IFU;
            cnt_d   = CNT_W'(MEM_LAT);
            addr_d  = lsu_gnt ? lsu_req_addr : ifu_req_addr;
            wen_d   = lsu_gnt && lsu_req_wen;
            wdata_d = lsu_gnt ? lsu_req_wdata : '0;
            wstrb_d = lsu_gnt ? lsu_req_wstrb : '0;
        end else if (commit) begin
            state_d    = RESP;
            ifu_data_d = owner_q == IFU ? mem_read_data : ifu_data_q;
            lsu_data_d = owner_q == LSU ? mem_read_data : lsu_data_q;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (done) begin
            state_d = IDLE;
        end
    end

    // handshake outputs are forced low while reset is held
    always_comb begin
        ifu_req_ready  = !reset && state_q == IDLE && ifu_gnt;
        lsu_req_ready  = !reset && state_q == IDLE && lsu_gnt;
        ifu_resp_valid = !reset && state_q == RESP && owner_q == IFU;
        lsu_resp_valid = !reset && state_q == RESP && owner_q == LSU;
        mem_wen        = !reset && commit && wen_q;
    end

    assign ifu_resp_data = ifu_data_q;
    assign lsu_resp_data = lsu_data_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (MEM_LAT=0 and MEM_LAT=3 instances).
// Grant-order expectation follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wstrb, mem_wstrb;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_read_data;

    logic        ifu_req_ready_3, ifu_resp_valid_3, lsu_req_valid_3, lsu_req_ready_3;
    logic        lsu_resp_valid_3, lsu_resp_ready_3, mem_wen_3;
    logic [31:0] ifu_resp_data_3, lsu_req_addr_3, lsu_resp_data_3, mem_addr_3, mem_wdata_3;
    logic [3:0]  mem_wstrb_3;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_read_data(mem_read_data)
    );

    mem_arbiter #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .ifu_req_valid(1'b0), .ifu_req_ready(ifu_req_ready_3), .ifu_req_addr(32'h0),
        .ifu_resp_valid(ifu_resp_valid_3), .ifu_resp_ready(1'b1), .ifu_resp_data(ifu_resp_data_3),
        .lsu_req_valid(lsu_req_valid_3), .lsu_req_ready(lsu_req_ready_3), .lsu_req_addr(lsu_req_addr_3),
        .lsu_req_wen(1'b0), .lsu_req_wdata(32'h0), .lsu_req_wstrb(4'h0),
        .lsu_resp_valid(lsu_resp_valid_3), .lsu_resp_ready(lsu_resp_ready_3), .lsu_resp_data(lsu_resp_data_3),
        .mem_wen(mem_wen_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_wstrb(mem_wstrb_3),
        .mem_read_data(mem_addr_3 ^ 32'h5A5A_0000)
    );

    logic [31:0] mem [0:255];
    int wen_cnt = 0;
    assign mem_read_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wen) wen_cnt <= wen_cnt + 1;
        if (reset) begin
            mem[64]  <= 32'hDEAD_BEEF;
            mem[128] <= 32'hAAAA_AAAA;
            mem[192] <= 32'h1111_1111;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic lsu_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] data);
        int n;
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = wen; lsu_req_addr = addr;
        lsu_req_wdata = wdata; lsu_req_wstrb = strb;
        n = 0;
        @(negedge clk);
        while (!lsu_req_ready && n < 20) begin @(negedge clk); n++; end
        check("lsu_txn_accept", 32'(lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!lsu_resp_valid && n < 40) begin @(negedge clk); n++; end
        check("lsu_txn_resp", 32'(lsu_resp_valid), 32'd1);
        data = lsu_resp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  who, who_exp;
        int g, cyc, last;
        reset = 1'b1;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h100; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
        lsu_req_wdata = '0; lsu_req_wstrb = '0; lsu_resp_ready = 1'b1;
        lsu_req_valid_3 = 1'b0; lsu_req_addr_3 = '0; lsu_resp_ready_3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
        check("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
        check("rst_ifu_rvalid", 32'(ifu_resp_valid), 32'd0);
        check("rst_lsu_rvalid", 32'(lsu_resp_valid), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_lsu_rdata", lsu_resp_data, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // IFU read, MEM_LAT=0
        @(negedge clk);
        check("ifu_ready_T", 32'(ifu_req_ready), 32'd1);
        check("lsu_ready_T", 32'(lsu_req_ready), 32'd0);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h200;
        @(negedge clk);
        check("ifu_rvalid_T1", 32'(ifu_resp_valid), 32'd0);
        check("mem_addr_T1", mem_addr, 32'h100);
        @(negedge clk);
        check("ifu_rvalid_T2", 32'(ifu_resp_valid), 32'd1);
        check("ifu_rdata_T2", ifu_resp_data, 32'hDEAD_BEEF);
        check("lsu_rvalid_T2", 32'(lsu_resp_valid), 32'd0);

        // LSU partial write; request inputs scrambled after accept
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h200;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wstrb = 4'b0011;
        @(negedge clk);
        check("wr_ready_T", 32'(lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0; lsu_req_wdata = 32'hFFFF_FFFF; lsu_req_addr = 32'h100; lsu_req_wstrb = 4'hF;
        @(negedge clk);
        check("wr_mem_wen", 32'(mem_wen), 32'd1);
        check("wr_mem_wstrb", 32'(mem_wstrb), 32'h3);
        check("wr_mem_addr", mem_addr, 32'h200);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        check("wr_mem_wen_off", 32'(mem_wen), 32'd0);
        check("wr_rvalid", 32'(lsu_resp_valid), 32'd1);
        check("wr_old_word", lsu_resp_data, 32'hAAAA_AAAA);
        check("wr_pulse_cnt", wen_cnt, 32'd1);
        lsu_txn(1'b0, 32'h200, 32'h0, 4'h0, rd);
        check("rd_after_wr", rd, 32'hAAAA_5678);

        // MEM_LAT=3 read with a stalled response
        @(posedge clk); #1;
        lsu_req_valid_3 = 1'b1; lsu_req_addr_3 = 32'h40;
        @(negedge clk);
        check("l3_ready_T", 32'(lsu_req_ready_3), 32'd1);
        @(posedge clk); #1;
        lsu_req_addr_3 = 32'h80;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("l3_wait_rvalid", 32'(lsu_resp_valid_3), 32'd0);
            check("l3_wait_addr", mem_addr_3, 32'h40);
            check("l3_wait_ready", 32'(lsu_req_ready_3), 32'd0);
        end
        for (int k = 5; k <= 8; k++) begin
            @(negedge clk);
            check("l3_hold_rvalid", 32'(lsu_resp_valid_3), 32'd1);
            check("l3_hold_rdata", lsu_resp_data_3, 32'h5A5A_0040);
            check("l3_hold_ready", 32'(lsu_req_ready_3), 32'd0);
        end
        @(posedge clk); #1 lsu_resp_ready_3 = 1'b1;
        @(negedge clk);
        check("l3_rr_rvalid", 32'(lsu_resp_valid_3), 32'd1);
        check("l3_rr_ready", 32'(lsu_req_ready_3), 32'd0);
        @(negedge clk);
        check("l3_next_ready", 32'(lsu_req_ready_3), 32'd1);
        check("l3_next_rvalid", 32'(lsu_resp_valid_3), 32'd0);
        lsu_req_valid_3 = 1'b0;

        // reset during the ACCESS cycle of a write
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h300;
        lsu_req_wdata = 32'h2222_2222; lsu_req_wstrb = 4'hF;
        @(negedge clk);
        check("mid_ready_T", 32'(lsu_req_ready), 32'd1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("mid_mem_wen", 32'(mem_wen), 32'd0);
        check("mid_lsu_rvalid", 32'(lsu_resp_valid), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_lsu_rvalid", 32'(lsu_resp_valid), 32'd0);
        check("post_ifu_rvalid", 32'(ifu_resp_valid), 32'd0);
        check("post_mem_wen", 32'(mem_wen), 32'd0);
        check("post_lsu_rdata", lsu_resp_data, 32'h0);
        check("post_pulse_cnt", wen_cnt, 32'd1);
        lsu_txn(1'b0, 32'h300, 32'h0, 4'h0, rd);
        check("post_rd", rd, 32'h1111_1111);

        // both ports requesting continuously after a fresh reset
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h200;
        g = 0; cyc = 0; last = 0; who = '0;
        while (g < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ifu_req_ready || lsu_req_ready) begin
                check("grant_onehot", 32'(ifu_req_ready & lsu_req_ready), 32'd0);
                who[g] = lsu_req_ready;
                if (g > 0) check("accept_gap", cyc - last, 32'd3);
                last = cyc;
                g++;
            end
        end
        check("grant_count", g, 32'd4);
`ifdef MEM_ARB_RR_EN
        who_exp = 4'b0101;
`else
        who_exp = 4'b1111;
`endif
        check("grant_seq", 32'(who), 32'(who_exp));
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
